// File: rtl/ram_master_pkg.sv
// rtl/ram_master_pkg.sv - state encoding and default constants shared by ram_master
package ram_master_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;
  localparam int RD_LAT = 2;
  localparam int WR_LAT = 1;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD_ADDR,
    RD_DATA,
    TURN
  } state_e;

endpackage

// File: rtl/ram_master.sv
// rtl/ram_master.sv - 8-bit RAM bus initiator: single read/write requests in, one-cycle response out
// Optional macro RAM_MASTER_TURNAROUND_EN inserts a dead TURN cycle after every read.
module ram_master
  import ram_master_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_W,
  parameter int DATA_WIDTH = DATA_W
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_we,
  output logic                  mem_oe,
  inout  wire  [DATA_WIDTH-1:0] mem_data
);

  state_e                state_q;
  logic                  req_ready_q;
  logic                  rsp_valid_q;
  logic [DATA_WIDTH-1:0] rsp_rdata_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  mem_we_q;
  logic                  mem_oe_q;

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign mem_addr  = mem_addr_q;
  assign mem_we    = mem_we_q;
  assign mem_oe    = mem_oe_q;

  // Drive enable is the registered write strobe, so the bus is released in every non-WR state.
  assign mem_data  = mem_we_q ? wdata_q : {DATA_WIDTH{1'bz}};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      mem_addr_q  <= '0;
      wdata_q     <= '0;
      mem_we_q    <= 1'b0;
      mem_oe_q    <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            mem_addr_q  <= req_addr;
            wdata_q     <= req_wdata;
            req_ready_q <= 1'b0;
            if (req_write) begin
              mem_we_q <= 1'b1;
              state_q  <= WR;
            end else begin
              state_q  <= RD_ADDR;
            end
          end
        end
        WR: begin
          mem_we_q    <= 1'b0;
          rsp_valid_q <= 1'b1;
          req_ready_q <= 1'b1;
          state_q     <= IDLE;
        end
        RD_ADDR: begin
          mem_oe_q <= 1'b1;
          state_q  <= RD_DATA;
        end
        RD_DATA: begin
          rsp_rdata_q <= mem_data;
          mem_oe_q    <= 1'b0;
          rsp_valid_q <= 1'b1;
`ifdef RAM_MASTER_TURNAROUND_EN
          state_q     <= TURN;
`else
          req_ready_q <= 1'b1;
          state_q     <= IDLE;
`endif
        end
        TURN: begin
          req_ready_q <= 1'b1;
          state_q     <= IDLE;
        end
        default: begin
          mem_we_q    <= 1'b0;
          mem_oe_q    <= 1'b0;
          req_ready_q <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_master.sv
// tb/tb_ram_master.sv - directed and table-driven bench for ram_master with a behavioural RAM
module tb_ram_master;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       req_valid;
  logic       req_ready;
  logic       req_write;
  logic [7:0] req_addr;
  logic [7:0] req_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic [7:0] mem_addr;
  logic       mem_we;
  logic       mem_oe;
  wire  [7:0] mem_data;

  int tests = 0;
  int fails = 0;
  int viol  = 0;

`ifdef RAM_MASTER_TURNAROUND_EN
  localparam int RD_GAP = 4;
`else
  localparam int RD_GAP = 3;
`endif

  always #5 clk = ~clk;

  ram_master #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_oe    (mem_oe),
    .mem_data  (mem_data)
  );

  // Behavioural RAM: write on edge with we, registered read buffer, drives only while oe.
  logic [7:0] ram    [256];
  logic [7:0] shadow [256];
  logic [7:0] rd_buf;

  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_data;
    rd_buf <= ram[mem_addr];
  end
  assign mem_data = mem_oe ? rd_buf : 8'hzz;

  logic [7:0] prev_rdata;
  always @(negedge clk) begin
    if (reset_n) begin
      if (mem_we && mem_oe) viol++;
      if (mem_oe && mem_data !== rd_buf) viol++;
      if (rsp_rdata !== prev_rdata && !rsp_valid) viol++;
    end
    prev_rdata = rsp_rdata;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_req(input logic wr, input logic [7:0] a, input logic [7:0] d,
                        output logic [7:0] rd, output int lat, output int wec, output int oec);
    int w;
    @(negedge clk);
    req_write = wr; req_addr = a; req_wdata = d; req_valid = 1'b1;
    w = 0;
    while (!req_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    lat = -1; wec = 0; oec = 0; rd = 8'h00;
    if (!req_ready) begin
      check("accept_timeout", 32'd0, 32'd1);
      req_valid = 1'b0;
      return;
    end
    @(negedge clk);
    req_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 10) begin
      wec += int'(mem_we);
      oec += int'(mem_oe);
      @(negedge clk);
      lat++;
    end
    rd = rsp_rdata;
    if (!rsp_valid) check("rsp_timeout", 32'd0, 32'd1);
    else if (wr) shadow[a] = d;
  endtask

  typedef struct {
    logic       wr;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rdata;
  } vec_t;

  typedef struct {
    logic       wr;
    logic [7:0] addr;
    logic [7:0] wdata;
  } op_t;

  initial begin
    vec_t       vecs[7];
    op_t        b2b[4];
    int         acc_cyc[4];
    logic       rsp_at_acc[4];
    logic [7:0] rsp_data[4];
    logic [7:0] rd;
    int         lat, wec, oec, idx, nresp;
    logic       accepted, turn_pending;

    vecs[0] = '{1'b1, 8'h10, 8'h3C, 8'h00};
    vecs[1] = '{1'b0, 8'h10, 8'h00, 8'h3C};
    vecs[2] = '{1'b1, 8'h00, 8'hA5, 8'h00};
    vecs[3] = '{1'b0, 8'h00, 8'h00, 8'hA5};
    vecs[4] = '{1'b1, 8'hFF, 8'h5A, 8'h00};
    vecs[5] = '{1'b0, 8'hFF, 8'h00, 8'h5A};
    vecs[6] = '{1'b0, 8'h11, 8'h00, 8'h00};

    b2b[0] = '{1'b1, 8'hFF, 8'hFF};
    b2b[1] = '{1'b1, 8'h00, 8'h01};
    b2b[2] = '{1'b0, 8'hFF, 8'h00};
    b2b[3] = '{1'b0, 8'h00, 8'h00};

    for (int i = 0; i < 256; i++) begin
      ram[i] = 8'h00;
      shadow[i] = 8'h00;
    end

    // Reset held while upstream is trying to issue a write.
    reset_n = 1'b0; req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h55; req_wdata = 8'h77;
    repeat (3) @(negedge clk);
    check("rst_req_ready", req_ready, 1'b1);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_mem_we",    mem_we,    1'b0);
    check("rst_mem_oe",    mem_oe,    1'b0);
    check("rst_mem_addr",  mem_addr,  8'h00);
    check("rst_rsp_rdata", rsp_rdata, 8'h00);
    req_valid = 1'b0;
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_no_we", mem_we, 1'b0);
    check("idle_no_oe", mem_oe, 1'b0);
    check("idle_ready", req_ready, 1'b1);

    for (int i = 0; i < 7; i++) begin
      do_req(vecs[i].wr, vecs[i].addr, vecs[i].wdata, rd, lat, wec, oec);
      check($sformatf("vec%0d_latency", i), lat, vecs[i].wr ? 32'd1 : 32'd2);
      check($sformatf("vec%0d_we_cycles", i), wec, vecs[i].wr ? 32'd1 : 32'd0);
      check($sformatf("vec%0d_oe_cycles", i), oec, vecs[i].wr ? 32'd0 : 32'd1);
      if (!vecs[i].wr) check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
      @(negedge clk);
      check($sformatf("vec%0d_addr_hold", i), mem_addr, vecs[i].addr);
    end

    // Back-to-back with req_valid held high across all four requests.
    repeat (3) @(negedge clk);
    idx = 0; nresp = 0; turn_pending = 1'b0;
    req_write = b2b[0].wr; req_addr = b2b[0].addr; req_wdata = b2b[0].wdata; req_valid = 1'b1;
    for (int c = 0; c < 40 && nresp < 4; c++) begin
      accepted = 1'b0;
      if (turn_pending) begin
        check("turn_ready_low", req_ready, 1'b0);
        check("turn_oe_low", mem_oe, 1'b0);
        turn_pending = 1'b0;
      end
      if (req_valid && req_ready) begin
        acc_cyc[idx] = c;
        rsp_at_acc[idx] = rsp_valid;
        accepted = 1'b1;
      end
      if (rsp_valid) begin
        rsp_data[nresp] = rsp_rdata;
        nresp++;
`ifdef RAM_MASTER_TURNAROUND_EN
        if (nresp >= 3) turn_pending = 1'b1;
`endif
      end
      @(negedge clk);
      if (accepted) begin
        idx++;
        if (idx < 4) begin
          req_write = b2b[idx].wr; req_addr = b2b[idx].addr; req_wdata = b2b[idx].wdata;
        end else begin
          req_valid = 1'b0;
        end
      end
    end
    req_valid = 1'b0;
    check("b2b_responses", nresp, 32'd4);
    check("b2b_gap_wr_wr", acc_cyc[1] - acc_cyc[0], 32'd2);
    check("b2b_gap_wr_rd", acc_cyc[2] - acc_cyc[1], 32'd2);
    check("b2b_gap_rd_rd", acc_cyc[3] - acc_cyc[2], RD_GAP);
    check("b2b_accept_in_rsp1", rsp_at_acc[1], 1'b1);
    check("b2b_accept_in_rsp2", rsp_at_acc[2], 1'b1);
    check("b2b_rd_ff", rsp_data[2], 8'hFF);
    check("b2b_rd_00", rsp_data[3], 8'h01);
    shadow[8'hFF] = 8'hFF;
    shadow[8'h00] = 8'h01;

    // Reset pulled while the write sits in WR, before its RAM edge.
    repeat (3) @(negedge clk);
    req_write = 1'b1; req_addr = 8'h20; req_wdata = 8'hAA; req_valid = 1'b1;
    @(posedge clk);
    #2;
    check("midwr_we_before", mem_we, 1'b1);
    reset_n = 1'b0;
    req_valid = 1'b0;
    #1;
    check("midwr_we_released", mem_we, 1'b0);
    check("midwr_ready", req_ready, 1'b1);
    check("midwr_addr", mem_addr, 8'h00);
    repeat (2) @(negedge clk);
    check("midwr_no_rsp", rsp_valid, 1'b0);
    check("midwr_ram_0x20", ram[8'h20], 8'h00);
    reset_n = 1'b1;
    do_req(1'b0, 8'h20, 8'h00, rd, lat, wec, oec);
    check("midwr_readback", rd, 8'h00);

    // Random mixed stream, checked against the shadow memory.
    for (int i = 0; i < 200; i++) begin
      logic       w;
      logic [7:0] a, d;
      logic [7:0] exp;
      w = 1'($urandom_range(0, 1));
      a = 8'($urandom_range(0, 255));
      d = 8'($urandom_range(0, 255));
      exp = shadow[a];
      do_req(w, a, d, rd, lat, wec, oec);
      if (!w) check($sformatf("rand%0d_rdata", i), rd, exp);
    end

    repeat (3) @(negedge clk);
    check("bus_violations", viol, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
